// File: rtl/issue_queue_if.sv
// Producer/consumer bundle of the id1 -> issue instruction queue.
// master drives pushes and pop count (id1 + issue side); slave is the queue itself.
interface issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 211,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             push0_valid;
  logic [WIDTH-1:0] push0_data;
  logic             push1_valid;
  logic [WIDTH-1:0] push1_data;
  logic             full;
  logic [1:0]       pop_cnt;
  logic             head0_valid;
  logic [WIDTH-1:0] head0_data;
  logic             head1_valid;
  logic [WIDTH-1:0] head1_data;
  logic [CNT_W-1:0] count;

  modport master (
    output push0_valid, push0_data, push1_valid, push1_data, pop_cnt,
    input  full, head0_valid, head0_data, head1_valid, head1_data, count
  );

  modport slave (
    input  push0_valid, push0_data, push1_valid, push1_data, pop_cnt,
    output full, head0_valid, head0_data, head1_valid, head1_data, count
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-push / dual-head instruction queue between id1 and issue.
// Define ISSUE_QUEUE_HWM_EN to add the hwm (occupancy high-water-mark) output.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 211,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         exception_flush,
  input  logic         stall,
  issue_queue_if.slave q
`ifdef ISSUE_QUEUE_HWM_EN
  ,
  output logic [CNT_W-1:0] hwm
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [PTR_W-1:0] rd_ptr1, wr_ptr1;
  logic             clear, hold, full;
  logic [1:0]       push_n, pop_req, pop_eff;
  logic [WIDTH-1:0] wr_data0;

  assign rd_ptr1 = rd_ptr + PTR_W'(1);
  assign wr_ptr1 = wr_ptr + PTR_W'(1);

  // A stalled branch flush is held off entirely; upstream repeats it later.
  assign clear = rst | exception_flush | (flush & ~stall);
  assign hold  = flush & stall;
  assign full  = count > CNT_W'(DEPTH - 2);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_n   = 2'd0;
    wr_data0 = q.push0_data;
    if (!clear && !hold && !full) begin
      unique case ({q.push0_valid, q.push1_valid})
        2'b11:   push_n = 2'd2;
        2'b10:   push_n = 2'd1;
        2'b01: begin
          push_n   = 2'd1;
          wr_data0 = q.push1_data;
        end
        default: push_n = 2'd0;
      endcase
    end
  end

  always_comb begin
    pop_req = (q.pop_cnt == 2'd0) ? 2'd0 : (q.pop_cnt == 2'd1) ? 2'd1 : 2'd2;
    pop_eff = 2'd0;
    if (!stall && !clear && !hold)
      pop_eff = (count < CNT_W'(pop_req)) ? count[1:0] : pop_req;
    count_next = clear ? '0 : count + CNT_W'(push_n) - CNT_W'(pop_eff);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_eff);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count_next;
    end
  end

  // NOTE: storage is deliberately not reset; count/valid gating hides stale entries.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr]  <= wr_data0;
    if (push_n == 2'd2) mem[wr_ptr1] <= q.push1_data;
  end

`ifdef ISSUE_QUEUE_HWM_EN
  always_ff @(posedge clk) begin
    if (rst)                   hwm <= '0;
    else if (count_next > hwm) hwm <= count_next;
  end
`endif

  always_comb begin
    q.full        = full;
    q.count       = count;
    q.head0_valid = count >= CNT_W'(1);
    q.head1_valid = count >= CNT_W'(2);
    q.head0_data  = q.head0_valid ? mem[rd_ptr]  : '0;
    q.head1_data  = q.head1_valid ? mem[rd_ptr1] : '0;
  end

  // Producer must honour full; the dropped push is flagged in simulation only.
  always_ff @(posedge clk) begin
    if (!rst && !clear)
      assert (!(full && (q.push0_valid || q.push1_valid)))
        else $warning("issue_queue: push while full dropped");
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH=8, WIDTH=211).
// Build with +define+ISSUE_QUEUE_HWM_EN to also check the high-water mark.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int WIDTH = 211;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, flush, exception_flush, stall;
  int   total = 0;
  int   bad   = 0;

  issue_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

`ifdef ISSUE_QUEUE_HWM_EN
  logic [CNT_W-1:0] hwm;
`endif

  issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .exception_flush (exception_flush),
    .stall           (stall),
    .q               (bus)
`ifdef ISSUE_QUEUE_HWM_EN
    ,
    .hwm             (hwm)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ent(input int n);
    logic [WIDTH-1:0] v;
    v = '0;
    v[31:0]           = 32'hA500_0000 + n;
    v[WIDTH-1:WIDTH-32] = ~(32'hA500_0000 + n);
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One clock with the given push/pop stimulus, then inputs return to idle.
  task automatic cyc(input logic v0, input int n0, input logic v1, input int n1,
                     input logic [1:0] pc);
    bus.push0_valid = v0;
    bus.push0_data  = v0 ? ent(n0) : '0;
    bus.push1_valid = v1;
    bus.push1_data  = v1 ? ent(n1) : '0;
    bus.pop_cnt     = pc;
    @(posedge clk);
    #1;
    bus.push0_valid = 1'b0;
    bus.push1_valid = 1'b0;
    bus.push0_data  = '0;
    bus.push1_data  = '0;
    bus.pop_cnt     = 2'd0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; exception_flush = 1'b0; stall = 1'b0;
    bus.push0_valid = 1'b0; bus.push1_valid = 1'b0;
    bus.push0_data = '0; bus.push1_data = '0; bus.pop_cnt = 2'd0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);

    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_h0v", bus.head0_valid, 0);
    check("rst_h1v", bus.head1_valid, 0);
    check("rst_h0d", bus.head0_data, 0);
    check("rst_h1d", bus.head1_data, 0);

    // Pair push then double pop
    cyc(1, 1, 1, 2, 0);
    check("ab_count", bus.count, 2);
    check("ab_h0", bus.head0_data, ent(1));
    check("ab_h1", bus.head1_data, ent(2));
    check("ab_h1v", bus.head1_valid, 1);
    cyc(0, 0, 0, 0, 2);
    check("ab_pop_count", bus.count, 0);
    check("ab_pop_h0v", bus.head0_valid, 0);
    check("ab_pop_h0d", bus.head0_data, 0);

    // Fill to the full threshold and beyond
    cyc(1, 3, 1, 4, 0);
    cyc(1, 5, 1, 6, 0);
    cyc(1, 7, 1, 8, 0);
    check("fill6_count", bus.count, 6);
    check("fill6_full", bus.full, 0);
    cyc(1, 9, 1, 10, 0);
    check("fill8_count", bus.count, 8);
    check("fill8_full", bus.full, 1);
`ifdef ISSUE_QUEUE_HWM_EN
    check("hwm_fill", hwm, 8);
`endif
    cyc(1, 11, 1, 12, 0);
    check("ovf_count", bus.count, 8);
    check("ovf_h0", bus.head0_data, ent(3));
    cyc(0, 0, 0, 0, 1);
    check("pop1_count", bus.count, 7);
    check("pop1_full", bus.full, 1);
    check("pop1_h0", bus.head0_data, ent(4));
    cyc(0, 0, 0, 0, 1);
    check("pop2_count", bus.count, 6);
    check("pop2_full", bus.full, 0);
    check("pop2_h0", bus.head0_data, ent(5));
    check("pop2_h1", bus.head1_data, ent(6));
    cyc(0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 2);
    check("drain_count", bus.count, 0);

    // Wrap: entries 20..25 occupy indices 2..7, then 30..33 land on 0..3
    cyc(1, 20, 1, 21, 0);
    cyc(1, 22, 1, 23, 0);
    cyc(1, 24, 1, 25, 0);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 2);
    check("wrap_empty", bus.count, 0);
    cyc(1, 30, 1, 31, 0);
    cyc(1, 32, 1, 33, 0);
    cyc(0, 0, 0, 0, 2);
    check("wrap_count", bus.count, 2);
    check("wrap_h0", bus.head0_data, ent(32));
    check("wrap_h1", bus.head1_data, ent(33));
    cyc(0, 0, 0, 0, 2);

    // Slot-1-only push is compacted; over-pop clamps to occupancy
    cyc(0, 0, 1, 40, 0);
    check("c_count", bus.count, 1);
    check("c_h0", bus.head0_data, ent(40));
    check("c_h1v", bus.head1_valid, 0);
    check("c_h1d", bus.head1_data, 0);
    cyc(0, 0, 0, 0, 2);
    check("c_pop_count", bus.count, 0);
    check("c_pop_h0v", bus.head0_valid, 0);

    // pop_cnt=3 behaves as 2; push and pop in the same cycle
    cyc(1, 41, 1, 42, 0);
    cyc(1, 43, 0, 0, 3);
    check("pc3_count", bus.count, 1);
    check("pc3_h0", bus.head0_data, ent(43));
    cyc(1, 44, 0, 0, 1);
    check("pp_count", bus.count, 1);
    check("pp_h0", bus.head0_data, ent(44));
    cyc(0, 0, 0, 0, 1);

    // Stall suppresses pops
    cyc(1, 45, 1, 46, 0);
    stall = 1'b1;
    cyc(0, 0, 0, 0, 2);
    check("stall_count", bus.count, 2);
    check("stall_h0", bus.head0_data, ent(45));
    stall = 1'b0;
    cyc(0, 0, 0, 0, 2);

    // Branch flush is held off during stall
    cyc(1, 50, 1, 51, 0);
    cyc(1, 52, 0, 0, 0);
    check("pre_flush_count", bus.count, 3);
    stall = 1'b1; flush = 1'b1;
    cyc(0, 0, 0, 0, 2);
    check("flush_held_count", bus.count, 3);
    check("flush_held_h0", bus.head0_data, ent(50));
    stall = 1'b0;
    cyc(0, 0, 0, 0, 0);
    check("flush_count", bus.count, 0);
    check("flush_h0v", bus.head0_valid, 0);
    flush = 1'b0;

    // Exception flush wins over stall and discards the same-cycle push
    cyc(1, 60, 1, 61, 0);
    stall = 1'b1; exception_flush = 1'b1;
    cyc(1, 62, 1, 63, 0);
    check("exc_count", bus.count, 0);
    stall = 1'b0; exception_flush = 1'b0;
    cyc(0, 0, 0, 0, 0);
    check("exc_idle_count", bus.count, 0);
    check("exc_idle_h0v", bus.head0_valid, 0);
`ifdef ISSUE_QUEUE_HWM_EN
    check("hwm_kept", hwm, 8);
`endif

    // Reset mid-operation with a pending push
    cyc(1, 70, 1, 71, 0);
    check("pre_rst_count", bus.count, 2);
    rst = 1'b1;
    cyc(1, 72, 1, 73, 1);
    rst = 1'b0;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_full", bus.full, 0);
    check("mid_rst_h0d", bus.head0_data, 0);
`ifdef ISSUE_QUEUE_HWM_EN
    check("hwm_rst", hwm, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
